// File: rtl/parallel_argmax_tree.sv
// -----------------------------------------------------------------------------
// parallel_argmax_tree
//
// Pipelined comparator tree. Each accepted cycle, one vector of LANES signed
// values is reduced to its maximum and that maximum's lane index. There is one
// register stage per tree level (INDEX_WIDTH stages in total). Every stage also
// carries valid, last and chunk sidebands. Results feed a serial argmax
// accumulator that combines per-chunk results into a frame-level argmax.
//
// Ports
//   clk         clock; all state updates on the rising edge
//   rst         synchronous active-high reset; overrides hold
//   hold        1 = freeze the whole pipeline, including the chunk counter
//   in_valid    in_data carries a vector this cycle (ignored while hold=1)
//   in_last     vector is the final chunk of its frame (qualified by in_valid)
//   in_data     packed signed lanes; lane i at [i*WIDTH +: WIDTH]
//   out_valid   out_max / out_argmax / out_chunk are valid
//   out_last    result belongs to the final chunk of a frame
//   out_max     signed maximum over the lanes
//   out_argmax  lane index of out_max (lowest index on ties)
//   out_chunk   chunk number of this result within its frame
// -----------------------------------------------------------------------------
module parallel_argmax_tree #(
  parameter int WIDTH       = 8,
  parameter int LANES       = 16,
  parameter int INDEX_WIDTH = 4,
  parameter int CHUNK_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     hold,
  input  logic                     in_valid,
  input  logic                     in_last,
  input  logic [LANES*WIDTH-1:0]   in_data,
  output logic                     out_valid,
  output logic                     out_last,
  output logic [WIDTH-1:0]         out_max,
  output logic [INDEX_WIDTH-1:0]   out_argmax,
  output logic [CHUNK_WIDTH-1:0]   out_chunk
);

  // Registered tree nodes: LANES/2 + LANES/4 + ... + 1 = LANES-1.
  localparam int NODES = LANES - 1;
  // Flat view of the whole tree: the LANES input lanes followed by the nodes.
  localparam int ALL   = 2 * LANES - 1;
  localparam logic signed [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  // Offset of tree row s in the flat view (row 0 = input lanes,
  // row k+1 = registered level k).
  function automatic int row_base(input int s);
    return (2 * LANES) - ((2 * LANES) >> s);
  endfunction

  logic signed [WIDTH-1:0]       val_q [NODES];
  logic signed [WIDTH-1:0]       val_d [NODES];
  logic [INDEX_WIDTH-1:0]        idx_q [NODES];
  logic [INDEX_WIDTH-1:0]        idx_d [NODES];
  logic signed [WIDTH-1:0]       all_val [ALL];
  logic [INDEX_WIDTH-1:0]        all_idx [ALL];

  // Sidebands: bit/entry k belongs to tree level k.
  logic [INDEX_WIDTH-1:0]        valid_q;
  logic [INDEX_WIDTH-1:0]        last_q;
  logic [CHUNK_WIDTH-1:0]        chunk_q [INDEX_WIDTH];
  logic [CHUNK_WIDTH-1:0]        chunk_cnt_q;
  logic [CHUNK_WIDTH-1:0]        chunk_cnt_d;

  // Gather input lanes (with constant indices) and registered nodes into one
  // array so every level reads its operands the same way.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      all_val[i] = $signed(in_data[i*WIDTH +: WIDTH]);
      all_idx[i] = INDEX_WIDTH'(i);
    end
    for (int n = 0; n < NODES; n++) begin
      all_val[LANES+n] = val_q[n];
      all_idx[LANES+n] = idx_q[n];
    end
  end

  // Comparator nodes. Operand a is the lower-index half, b the higher. Only a
  // strictly greater b wins, so ties keep the lowest lane index.
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // assignment, so no path leaves it unassigned and no latch is inferred.
    for (int n = 0; n < NODES; n++) begin
      val_d[n] = MIN_VAL;
      idx_d[n] = '0;
    end
    for (int k = 0; k < INDEX_WIDTH; k++) begin
      for (int j = 0; j < (LANES >> (k + 1)); j++) begin
        if (all_val[row_base(k) + 2*j + 1] > all_val[row_base(k) + 2*j]) begin
          val_d[row_base(k+1) - LANES + j] = all_val[row_base(k) + 2*j + 1];
          idx_d[row_base(k+1) - LANES + j] = all_idx[row_base(k) + 2*j + 1];
        end else begin
          val_d[row_base(k+1) - LANES + j] = all_val[row_base(k) + 2*j];
          idx_d[row_base(k+1) - LANES + j] = all_idx[row_base(k) + 2*j];
        end
      end
    end
  end

  // Chunk number attached to the vector being accepted; a last chunk restarts
  // the count for the next frame. Natural wrap at 2^CHUNK_WIDTH.
  always_comb begin
    chunk_cnt_d = chunk_cnt_q;
    if (in_valid) begin
      chunk_cnt_d = in_last ? '0 : chunk_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the data/index node arrays are reset too, so out_max/out_argmax
    // show defined values straight after reset rather than stale data.
    if (rst) begin
      for (int n = 0; n < NODES; n++) begin
        val_q[n] <= MIN_VAL;
        idx_q[n] <= '0;
      end
      for (int k = 0; k < INDEX_WIDTH; k++) begin
        chunk_q[k] <= '0;
      end
      valid_q     <= '0;
      last_q      <= '0;
      chunk_cnt_q <= '0;
    end else if (!hold) begin
      // NOTE: non-blocking assignments let every stage sample the previous
      // stage's old value, which is what makes this a shift pipeline.
      for (int n = 0; n < NODES; n++) begin
        val_q[n] <= val_d[n];
        idx_q[n] <= idx_d[n];
      end
      valid_q[0]  <= in_valid;
      last_q[0]   <= in_valid & in_last;
      chunk_q[0]  <= chunk_cnt_q;
      for (int k = 1; k < INDEX_WIDTH; k++) begin
        valid_q[k] <= valid_q[k-1];
        last_q[k]  <= last_q[k-1];
        chunk_q[k] <= chunk_q[k-1];
      end
      chunk_cnt_q <= chunk_cnt_d;
    end
  end

  // Outputs come straight from the last level's registers.
  assign out_valid  = valid_q[INDEX_WIDTH-1];
  assign out_last   = last_q[INDEX_WIDTH-1];
  assign out_max    = val_q[NODES-1];
  assign out_argmax = idx_q[NODES-1];
  assign out_chunk  = chunk_q[INDEX_WIDTH-1];

endmodule

// File: tb/tb_parallel_argmax_tree.sv
// -----------------------------------------------------------------------------
// tb_parallel_argmax_tree
//
// Directed bench for parallel_argmax_tree with default parameters. Inputs are
// driven and outputs sampled on the falling edge; the DUT acts on the rising
// edge. A vector driven at falling edge t is expected at falling edge t+4.
// -----------------------------------------------------------------------------
module tb_parallel_argmax_tree;

  localparam int WIDTH = 8;
  localparam int LANES = 16;
  localparam int IW    = 4;
  localparam int CW    = 8;
  localparam int DW    = LANES * WIDTH;

  logic            clk = 1'b0;
  logic            rst;
  logic            hold;
  logic            in_valid;
  logic            in_last;
  logic [DW-1:0]   in_data;
  logic            out_valid;
  logic            out_last;
  logic [WIDTH-1:0] out_max;
  logic [IW-1:0]   out_argmax;
  logic [CW-1:0]   out_chunk;

  int checks   = 0;
  int failures = 0;

  parallel_argmax_tree #(
    .WIDTH(WIDTH), .LANES(LANES), .INDEX_WIDTH(IW), .CHUNK_WIDTH(CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hold       (hold),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .out_max    (out_max),
    .out_argmax (out_argmax),
    .out_chunk  (out_chunk)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] fill(input logic [WIDTH-1:0] x);
    logic [DW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*WIDTH +: WIDTH] = x;
    return v;
  endfunction

  function automatic logic [DW-1:0] set_lane(input logic [DW-1:0] v,
                                              input int lane,
                                              input logic [WIDTH-1:0] x);
    logic [DW-1:0] r;
    r = v;
    r[lane*WIDTH +: WIDTH] = x;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Full result check when a valid result is expected, valid-only otherwise.
  task automatic check_out(input string name, input logic ev,
                           input logic [WIDTH-1:0] em, input logic [IW-1:0] ei,
                           input logic [CW-1:0] ec, input logic el);
    check({name, ".valid"}, 32'(out_valid), 32'(ev));
    if (ev) begin
      check({name, ".max"},    32'(out_max),    32'(em));
      check({name, ".argmax"}, 32'(out_argmax), 32'(ei));
      check({name, ".chunk"},  32'(out_chunk),  32'(ec));
      check({name, ".last"},   32'(out_last),   32'(el));
    end
  endtask

  task automatic check_reset_state(input string name);
    check({name, ".valid"},  32'(out_valid),  32'(1'b0));
    check({name, ".last"},   32'(out_last),   32'(1'b0));
    check({name, ".max"},    32'(out_max),    32'(8'h80));
    check({name, ".argmax"}, 32'(out_argmax), 32'(4'd0));
    check({name, ".chunk"},  32'(out_chunk),  32'(8'd0));
  endtask

  task automatic drive(input logic v, input logic l, input logic [DW-1:0] d);
    in_valid = v;
    in_last  = l;
    in_data  = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // One isolated vector: out_valid must stay low for three cycles and rise on
  // the fourth.
  task automatic run_single(input string name, input logic [DW-1:0] d,
                            input logic [WIDTH-1:0] em, input logic [IW-1:0] ei,
                            input logic [CW-1:0] ec);
    drive(1'b1, 1'b1, d);
    step();
    idle();
    for (int i = 1; i < 4; i++) begin
      check_out($sformatf("%s.lat%0d", name, i), 1'b0, '0, '0, '0, 1'b0);
      step();
    end
    check_out(name, 1'b1, em, ei, ec, 1'b1);
  endtask

  initial begin
    logic [DW-1:0] d;

    // Reset with hold asserted: reset must still win.
    rst  = 1'b1;
    hold = 1'b1;
    idle();
    repeat (3) step();
    check_reset_state("reset");
    rst  = 1'b0;
    hold = 1'b0;
    step();

    // Single vector: lane 5 = 100, others -3. Sent as a last chunk so the
    // chunk counter stays at 0 for the following tests.
    d = set_lane(fill(8'hFD), 5, 8'd100);
    run_single("single", d, 8'd100, 4'd5, 8'd0);

    // Ties on lanes 2, 9, 15 resolve to lane 2.
    d = set_lane(set_lane(set_lane(fill(8'h00), 2, 8'd42), 9, 8'd42), 15, 8'd42);
    run_single("ties", d, 8'd42, 4'd2, 8'd0);

    // All -128 (lane 0 wins), then back-to-back lane 15 = -127.
    drive(1'b1, 1'b1, fill(8'h80));
    step();
    drive(1'b1, 1'b1, set_lane(fill(8'h80), 15, 8'h81));
    step();
    idle();
    step();
    step();
    check_out("allmin", 1'b1, 8'h80, 4'd0, 8'd0, 1'b1);
    step();
    check_out("lane15", 1'b1, 8'h81, 4'd15, 8'd0, 1'b1);
    step();

    // Stream of 6 chunks (last on the 6th) plus a 7th starting a new frame.
    // Vector i: lane (3i mod 16) = 10i+1, others -50.
    for (int t = 0; t <= 10; t++) begin
      if (t >= 4) begin
        check_out($sformatf("stream%0d", t - 4), 1'b1,
                  8'(10 * (t - 4) + 1), 4'((3 * (t - 4)) % 16),
                  (t - 4 == 6) ? 8'd0 : 8'(t - 4), (t - 4 == 5));
      end else begin
        check_out($sformatf("stream_pre%0d", t), 1'b0, '0, '0, '0, 1'b0);
      end
      if (t < 7) begin
        drive(1'b1, (t == 5), set_lane(fill(8'hCE), (3 * t) % 16, 8'(10 * t + 1)));
      end else begin
        idle();
      end
      step();
    end
    check_out("stream_drain", 1'b0, '0, '0, '0, 1'b0);

    // Hold for 3 cycles with 4 vectors in flight. Chunk counter is now 1.
    // Vector i: lane 15-i = 20+i, others -1. A vector offered during hold
    // (with in_last=1) must be dropped and must not touch the counter.
    for (int t = 0; t <= 15; t++) begin
      if (t < 4) begin
        check_out($sformatf("hold_pre%0d", t), 1'b0, '0, '0, '0, 1'b0);
      end else if (t <= 7) begin
        check_out($sformatf("hold_frz%0d", t), 1'b1, 8'd20, 4'd15, 8'd1, 1'b0);
      end else if (t <= 10) begin
        check_out($sformatf("hold_res%0d", t - 7), 1'b1, 8'(20 + t - 7),
                  4'(15 - (t - 7)), 8'(1 + t - 7), 1'b0);
      end else if (t < 15) begin
        check_out($sformatf("hold_gap%0d", t), 1'b0, '0, '0, '0, 1'b0);
      end else begin
        check_out("hold_extra", 1'b1, 8'h7F, 4'd7, 8'd5, 1'b0);
      end
      hold = (t >= 4 && t <= 6);
      if (t < 4) begin
        drive(1'b1, 1'b0, set_lane(fill(8'hFF), 15 - t, 8'(20 + t)));
      end else if (t == 5) begin
        drive(1'b1, 1'b1, fill(8'h7F));
      end else if (t == 11) begin
        drive(1'b1, 1'b0, set_lane(fill(8'h80), 7, 8'h7F));
      end else begin
        idle();
      end
      step();
    end

    // Reset for one cycle with 3 vectors in flight (chunks 6..8). Everything
    // in flight is discarded and the counter restarts at 0.
    for (int t = 0; t <= 12; t++) begin
      if (t == 4) begin
        check_reset_state("rst_mid");
      end else if (t > 4 && t < 12) begin
        check_out($sformatf("rst_quiet%0d", t), 1'b0, '0, '0, '0, 1'b0);
      end else if (t == 12) begin
        check_out("rst_first", 1'b1, 8'hFB, 4'd3, 8'd0, 1'b1);
      end
      rst  = (t == 3);
      hold = (t == 3);
      if (t < 3) begin
        drive(1'b1, 1'b0, set_lane(fill(8'h00), 0, 8'd50));
      end else if (t == 8) begin
        drive(1'b1, 1'b1, set_lane(fill(8'h9C), 3, 8'hFB));
      end else begin
        idle();
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parallel_argmax_tree.md
Name: parallel_argmax_tree

Overview:
Pipelined comparator tree that reduces one vector of LANES signed values per cycle to its maximum and that maximum's lane index. It sits directly upstream of the serial argmax accumulator. out_max, out_argmax and out_valid drive that stage's in, in_argmax and enable. Per-chunk results are combined downstream into a global argmax over a stream of chunks.

Parameters:
WIDTH, 8, bit width of each signed lane value
LANES, 16, lanes per input vector; power of two, >= 2
INDEX_WIDTH, 4, log2(LANES); width of the lane index
CHUNK_WIDTH, 8, width of the chunk counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
hold  input  1  1 = freeze entire pipeline (no state changes except reset)
in_valid  input  1  in_data holds a valid vector this cycle
in_last  input  1  vector is the final chunk of a frame; qualified by in_valid
in_data  input  LANES*WIDTH  packed signed lanes; lane i at bits [i*WIDTH +: WIDTH]
out_valid  output  1  out_max/out_argmax/out_chunk valid this cycle
out_last  output  1  result belongs to the final chunk of a frame
out_max  output  WIDTH  signed maximum over the vector's lanes
out_argmax  output  INDEX_WIDTH  lane index of out_max
out_chunk  output  CHUNK_WIDTH  chunk number of this result within its frame

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high.
- Structure:
  - INDEX_WIDTH register stages, one per tree level.
  - Level k holds LANES>>(k+1) (value, index) pairs.
  - Each level also registers valid, last and chunk sidebands.
- Latency: exactly INDEX_WIDTH cycles of non-hold clock edges, from in_valid sampled to out_valid.
- Throughput: one vector per non-hold cycle.
- Comparator node (lower-index operand a, higher-index b):
  - Select b only when b > a, signed compare.
  - Otherwise select a.
  - Ties therefore resolve to the lowest lane index, matching the downstream strict-greater rule.
- Indices are carried full-width INDEX_WIDTH from level 0; no arithmetic on indices.
- Values:
  - Signed two's-complement; no widening, no saturation.
  - Most negative value (-2^(WIDTH-1)) is a legal input.
- Bubbles:
  - Data/index registers of a stage with valid=0 may hold any value.
  - out_max/out_argmax are only meaningful when out_valid=1.
- hold=1:
  - All pipeline registers, sidebands and the chunk counter keep their values.
  - in_valid is ignored that cycle (input dropped; upstream must not present new data while hold=1).
  - Outputs stay stable.
- Chunk counter (input side):
  - On each accepted in_valid (hold=0), the current count is attached to the vector.
  - If in_last=1, the counter then clears to 0; otherwise it increments.
  - Wraps modulo 2^CHUNK_WIDTH without error.
- out_last = registered in_last of the same vector.
- in_last with in_valid=0 is ignored.
- Reset (rst=1, overrides hold):
  - All valid bits 0 (out_valid=0), out_last=0.
  - out_max = -2^(WIDTH-1), out_argmax=0, out_chunk=0, chunk counter=0.
  - Internal data registers cleared likewise.
  - Reset mid-operation discards all in-flight vectors; first post-reset output appears INDEX_WIDTH cycles after the first accepted vector.
- No combinational path from any input to any output.

Test Plan:
- Default params, reset, then one vector with lane 5 = 100, all others = -3, in_valid=1 → out_valid=1 exactly 4 cycles later with out_max=100, out_argmax=5, out_chunk=0.
- Ties: lanes 2, 9 and 15 all = 42, others 0 → out_max=42, out_argmax=2.
- All lanes = -128 → out_max=-128, out_argmax=0. Next vector with lane 15 = -127 → out_max=-127, out_argmax=15.
- Back-to-back stream of 6 vectors, last one with in_last=1, followed by a 7th vector → 6 consecutive out_valid cycles with out_chunk 0..5, out_last=1 only on chunk 5; 7th result shows out_chunk=0.
- Mid-stream hold: 4 vectors in flight, hold=1 for 3 cycles → outputs frozen, no out_valid pulses lost or duplicated; results resume in order after hold drops.
- Assert rst for 1 cycle while 3 vectors are in flight → out_valid stays 0 for the next 4 cycles. Counter restarts: first new result carries out_chunk=0.
